// File: rtl/branch_resolve_tracker.sv
// branch_resolve_tracker
// Initiator side of a 2-bit branch predictor interface. Fetch issues branches,
// one prediction request is sent per branch, and the returned prediction is
// queued in an in-order FIFO of in-flight branches. When the back end resolves
// the oldest branch, the outcome is forwarded to the predictor, mispredicts are
// flagged, and all younger branches, including one still being predicted, are
// flushed.
// Optional statistics counters are built only when BRANCH_STATS_EN is defined;
// otherwise stat_branches / stat_mispredicts are tied to zero.
module branch_resolve_tracker #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_issue,
    output logic             issue_ready,
    output logic             pred_request,
    input  logic             prediction,
    output logic             br_pred_valid,
    output logic             br_pred,
    input  logic             br_resolve,
    input  logic             br_actual_taken,
    output logic             resolve_ready,
    output logic             pred_result,
    output logic             pred_taken,
    output logic             mispredict,
    output logic             resolve_err,
    output logic [CNT_W-1:0] stat_branches,
    output logic [CNT_W-1:0] stat_mispredicts
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t           state;
    logic             kill;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             fifo_mem [DEPTH];

    logic             issue_acc_p0;
    logic             resolve_acc_p0;
    logic             head_pred_p0;
    logic             miss_p0;
    logic             push_p0;
    logic             pop_p0;

    // Resolve wins over issue so request and result strobes never coincide.
    assign issue_ready    = (state == IDLE) && (count < FULL_CNT) && !br_resolve;
    assign resolve_ready  = (count != '0);

    assign issue_acc_p0   = br_issue && issue_ready;
    assign resolve_acc_p0 = br_resolve && resolve_ready;
    assign head_pred_p0   = fifo_mem[rd_ptr];
    assign miss_p0        = resolve_acc_p0 && (head_pred_p0 != br_actual_taken);
    // A branch in flight is younger than every queued one, so a mispredict
    // (now or earlier in its REQ cycle) discards it instead of capturing it.
    assign push_p0        = (state == CAPTURE) && !kill && !miss_p0;
    assign pop_p0         = resolve_acc_p0 && !miss_p0;

    // Issue FSM: request strobe, prediction capture and discard tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            kill          <= 1'b0;
            pred_request  <= 1'b0;
            br_pred_valid <= 1'b0;
            br_pred       <= 1'b0;
        end else begin
            pred_request  <= 1'b0;
            br_pred_valid <= push_p0;
            if (push_p0) begin
                br_pred <= prediction;
            end
            case (state)
                IDLE: begin
                    kill <= 1'b0;
                    if (issue_acc_p0) begin
                        state        <= REQ;
                        pred_request <= 1'b1;
                    end
                end
                REQ: begin
                    state <= CAPTURE;
                    if (miss_p0) begin
                        kill <= 1'b1;
                    end
                end
                CAPTURE: begin
                    state <= IDLE;
                    kill  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    kill  <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointers and occupancy; a mispredict empties the queue outright.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (miss_p0) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_p0) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop_p0) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push_p0, pop_p0})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // FIFO storage holds only prediction bits, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push_p0) begin
            fifo_mem[wr_ptr] <= prediction;
        end
    end

    // Resolve side: one-cycle result, mispredict and error pulses.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pred_result <= 1'b0;
            pred_taken  <= 1'b0;
            mispredict  <= 1'b0;
            resolve_err <= 1'b0;
        end else begin
            pred_result <= resolve_acc_p0;
            pred_taken  <= resolve_acc_p0 && br_actual_taken;
            mispredict  <= miss_p0;
            resolve_err <= br_resolve && !resolve_ready;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] miss_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // Saturating resolve and mispredict counters.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            br_cnt   <= '0;
            miss_cnt <= '0;
        end else begin
            if (resolve_acc_p0) begin
                br_cnt <= sat_inc(br_cnt);
            end
            if (miss_p0) begin
                miss_cnt <= sat_inc(miss_cnt);
            end
        end
    end

    assign stat_branches    = br_cnt;
    assign stat_mispredicts = miss_cnt;
`else
    assign stat_branches    = '0;
    assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_tracker.sv
// Bench for branch_resolve_tracker: table-driven issue/resolve vectors with a
// scoreboard of expected predictor-side events, plus hand-written timing and
// flush sequences. With BRANCH_STATS_EN a narrow counter width is used so that
// saturation is reached quickly.
module tb_branch_resolve_tracker;

`ifdef BRANCH_STATS_EN
    localparam int CW = 4;
    localparam logic [CW-1:0] EXP_BR   = 4'd15;
    localparam logic [CW-1:0] EXP_MISS = 4'd1;
`else
    localparam int CW = 16;
    localparam logic [CW-1:0] EXP_BR   = '0;
    localparam logic [CW-1:0] EXP_MISS = '0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          br_issue = 1'b0;
    logic          prediction = 1'b0;
    logic          br_resolve = 1'b0;
    logic          br_actual_taken = 1'b0;
    logic          issue_ready, pred_request, br_pred_valid, br_pred;
    logic          resolve_ready, pred_result, pred_taken, mispredict, resolve_err;
    logic [CW-1:0] stat_branches, stat_mispredicts;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic taken;
        logic misp;
    } res_t;

    logic q_pred[$];
    res_t q_res[$];
    logic q_err[$];

    typedef struct {
        bit is_res;
        bit val;
        bit misp;
        bit exp_rr;
        bit exp_ir;
        bit hold;
    } vec_t;

    vec_t tbl[14];

    branch_resolve_tracker #(.DEPTH(4), .CNT_W(CW)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .br_issue        (br_issue),
        .issue_ready     (issue_ready),
        .pred_request    (pred_request),
        .prediction      (prediction),
        .br_pred_valid   (br_pred_valid),
        .br_pred         (br_pred),
        .br_resolve      (br_resolve),
        .br_actual_taken (br_actual_taken),
        .resolve_ready   (resolve_ready),
        .pred_result     (pred_result),
        .pred_taken      (pred_taken),
        .mispredict      (mispredict),
        .resolve_err     (resolve_err),
        .stat_branches   (stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    always #5 clk = ~clk;

    task automatic check1(input string name, input logic act, input logic exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b", name, act, exp_v);
        end
    endtask

    task automatic checkw(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp_v);
        end
    endtask

    // Scoreboard monitor: every predictor-side event must match a queued expectation.
    always @(negedge clk) begin
        logic e;
        res_t r;
        if (rst_n) begin
            if (pred_request || pred_result)
                check1("req_res_exclusive", pred_request && pred_result, 1'b0);
            if (br_pred_valid) begin
                if (q_pred.size() == 0) check1("unexpected_br_pred_valid", 1'b1, 1'b0);
                else begin
                    e = q_pred.pop_front();
                    check1("br_pred", br_pred, e);
                end
            end
            if (pred_result) begin
                if (q_res.size() == 0) check1("unexpected_pred_result", 1'b1, 1'b0);
                else begin
                    r = q_res.pop_front();
                    check1("pred_taken", pred_taken, r.taken);
                    check1("mispredict", mispredict, r.misp);
                end
            end
            if (mispredict && !pred_result)
                check1("mispredict_without_result", 1'b1, 1'b0);
            if (resolve_err) begin
                if (q_err.size() == 0) check1("unexpected_resolve_err", 1'b1, 1'b0);
                else e = q_err.pop_front();
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Called at a negedge; returns at the negedge of the br_pred_valid cycle.
    task automatic issue_branch(input logic p);
        int n = 0;
        br_issue   = 1'b1;
        prediction = p;
        #1;
        while (!issue_ready) begin
            @(negedge clk);
            n++;
            if (n > 20) begin
                check1("issue_timeout", 1'b1, 1'b0);
                br_issue = 1'b0;
                return;
            end
        end
        q_pred.push_back(p);
        cyc();
        br_issue = 1'b0;
        cyc();
        cyc();
        @(negedge clk);
        check1("br_pred_valid_issue", br_pred_valid, 1'b1);
    endtask

    // Called at a negedge with resolve_ready high; returns at the result cycle negedge.
    task automatic resolve_branch(input logic a, input logic misp);
        br_resolve      = 1'b1;
        br_actual_taken = a;
        q_res.push_back('{a, misp});
        cyc();
        br_resolve      = 1'b0;
        br_actual_taken = 1'b0;
        @(negedge clk);
        check1("pred_result_strobe", pred_result, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        //                is_res val misp rr ir hold
        tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[12] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset state
        rst_n = 1'b0;
        repeat (2) cyc();
        @(negedge clk);
        check1("rst_pred_request", pred_request, 1'b0);
        check1("rst_br_pred_valid", br_pred_valid, 1'b0);
        check1("rst_pred_result", pred_result, 1'b0);
        check1("rst_mispredict", mispredict, 1'b0);
        check1("rst_resolve_err", resolve_err, 1'b0);
        check1("rst_resolve_ready", resolve_ready, 1'b0);
        checkw("rst_stat_branches", stat_branches, '0);
        rst_n = 1'b1;

        // First issue: request in cycle 1, prediction valid in cycle 3
        br_issue   = 1'b1;
        prediction = 1'b1;
        #1;
        check1("first_issue_ready", issue_ready, 1'b1);
        q_pred.push_back(1'b1);
        cyc();
        br_issue = 1'b0;
        @(negedge clk);
        check1("c1_pred_request", pred_request, 1'b1);
        cyc();
        @(negedge clk);
        check1("c2_pred_request", pred_request, 1'b0);
        check1("c2_br_pred_valid", br_pred_valid, 1'b0);
        cyc();
        @(negedge clk);
        check1("c3_br_pred_valid", br_pred_valid, 1'b1);
        check1("c3_resolve_ready", resolve_ready, 1'b1);
        resolve_branch(1'b1, 1'b0);
        check1("first_resolve_empty", resolve_ready, 1'b0);

        // Table-driven issue/resolve vectors (fill, wrap, flush)
        for (int i = 0; i < 14; i++) begin
            if (tbl[i].is_res) resolve_branch(tbl[i].val, tbl[i].misp);
            else issue_branch(tbl[i].val);
            check1("tbl_resolve_ready", resolve_ready, tbl[i].exp_rr);
            check1("tbl_issue_ready", issue_ready, tbl[i].exp_ir);
            if (tbl[i].hold) begin
                br_issue = 1'b1;
                #1;
                for (int k = 0; k < 3; k++) begin
                    check1("full_issue_ready", issue_ready, 1'b0);
                    check1("full_pred_request", pred_request, 1'b0);
                    @(negedge clk);
                end
                br_issue = 1'b0;
            end
        end

        // Mispredict while a younger branch is in CAPTURE
        issue_branch(1'b0);
        issue_branch(1'b1);
        issue_branch(1'b1);
        br_issue   = 1'b1;
        prediction = 1'b1;
        #1;
        check1("cap_issue_ready", issue_ready, 1'b1);
        cyc();
        br_issue = 1'b0;
        cyc();
        br_resolve      = 1'b1;
        br_actual_taken = 1'b1;
        q_res.push_back('{1'b1, 1'b1});
        cyc();
        br_resolve      = 1'b0;
        br_actual_taken = 1'b0;
        @(negedge clk);
        check1("cap_mispredict", mispredict, 1'b1);
        check1("cap_pred_result", pred_result, 1'b1);
        check1("cap_no_pred_valid", br_pred_valid, 1'b0);
        check1("cap_flushed", resolve_ready, 1'b0);
        cyc();
        @(negedge clk);
        check1("cap_no_pred_valid2", br_pred_valid, 1'b0);
        br_resolve      = 1'b1;
        br_actual_taken = 1'b1;
        q_err.push_back(1'b1);
        cyc();
        br_resolve      = 1'b0;
        br_actual_taken = 1'b0;
        @(negedge clk);
        check1("empty_resolve_err", resolve_err, 1'b1);
        check1("empty_no_result", pred_result, 1'b0);

        // Mispredict while a younger branch is in REQ
        issue_branch(1'b0);
        br_issue   = 1'b1;
        prediction = 1'b1;
        #1;
        check1("req_issue_ready", issue_ready, 1'b1);
        cyc();
        br_issue        = 1'b0;
        br_resolve      = 1'b1;
        br_actual_taken = 1'b1;
        q_res.push_back('{1'b1, 1'b1});
        cyc();
        br_resolve      = 1'b0;
        br_actual_taken = 1'b0;
        @(negedge clk);
        check1("req_mispredict", mispredict, 1'b1);
        cyc();
        @(negedge clk);
        check1("req_no_pred_valid", br_pred_valid, 1'b0);
        cyc();
        @(negedge clk);
        check1("req_no_pred_valid2", br_pred_valid, 1'b0);
        check1("req_flushed", resolve_ready, 1'b0);
        check1("req_idle_ready", issue_ready, 1'b1);

        // Issue and resolve together: resolve wins, issue waits one cycle
        issue_branch(1'b1);
        br_issue        = 1'b1;
        br_resolve      = 1'b1;
        br_actual_taken = 1'b1;
        prediction      = 1'b0;
        q_res.push_back('{1'b1, 1'b0});
        #1;
        check1("both_issue_blocked", issue_ready, 1'b0);
        check1("both_resolve_ready", resolve_ready, 1'b1);
        cyc();
        br_resolve      = 1'b0;
        br_actual_taken = 1'b0;
        q_pred.push_back(1'b0);
        @(negedge clk);
        check1("both_pred_result", pred_result, 1'b1);
        check1("both_no_request", pred_request, 1'b0);
        check1("both_issue_now_ready", issue_ready, 1'b1);
        cyc();
        br_issue = 1'b0;
        @(negedge clk);
        check1("both_late_request", pred_request, 1'b1);
        check1("both_late_no_result", pred_result, 1'b0);
        cyc();
        cyc();
        @(negedge clk);
        check1("both_pred_valid", br_pred_valid, 1'b1);
        resolve_branch(1'b0, 1'b0);
        check1("both_empty", resolve_ready, 1'b0);

        // Reset in the middle of a request drops it silently
        br_issue   = 1'b1;
        prediction = 1'b1;
        #1;
        cyc();
        br_issue = 1'b0;
        rst_n    = 1'b0;
        cyc();
        cyc();
        rst_n = 1'b1;
        @(negedge clk);
        check1("midrst_pred_valid", br_pred_valid, 1'b0);
        check1("midrst_resolve_ready", resolve_ready, 1'b0);
        checkw("midrst_stat_branches", stat_branches, '0);
        checkw("midrst_stat_mispredicts", stat_mispredicts, '0);
        cyc();
        @(negedge clk);
        check1("midrst_pred_valid2", br_pred_valid, 1'b0);
        check1("midrst_pred_request", pred_request, 1'b0);

        // Statistics: 20 correct resolves then one mispredict
        for (int i = 0; i < 20; i++) begin
            issue_branch(1'b1);
            resolve_branch(1'b1, 1'b0);
        end
        issue_branch(1'b0);
        resolve_branch(1'b1, 1'b1);
        checkw("stat_branches", stat_branches, EXP_BR);
        checkw("stat_mispredicts", stat_mispredicts, EXP_MISS);

        // Every expected event must have been observed
        repeat (3) cyc();
        check1("pred_queue_drained", q_pred.size() == 0, 1'b1);
        check1("res_queue_drained", q_res.size() == 0, 1'b1);
        check1("err_queue_drained", q_err.size() == 0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
